// File: rtl/mem_dmem_pkg.sv
// rtl/mem_dmem_pkg.sv - memory op codes, MEM-stage FSM states and op decode helpers
package mem_dmem_pkg;

    localparam logic [7:0] MEM_NOP = 8'h00;
    localparam logic [7:0] MEM_LB  = 8'h20;
    localparam logic [7:0] MEM_LH  = 8'h21;
    localparam logic [7:0] MEM_LW  = 8'h23;
    localparam logic [7:0] MEM_LBU = 8'h24;
    localparam logic [7:0] MEM_LHU = 8'h25;
    localparam logic [7:0] MEM_SB  = 8'h28;
    localparam logic [7:0] MEM_SH  = 8'h29;
    localparam logic [7:0] MEM_SW  = 8'h2B;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    function automatic logic is_load(input logic [7:0] op);
        return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return op inside {MEM_SB, MEM_SH, MEM_SW};
    endfunction

    function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] addr_lo);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: return addr_lo[0];
            MEM_LW, MEM_SW:          return addr_lo != 2'b00;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering: store replication, be_n, load extraction/extension
module mem_lane_align
    import mem_dmem_pkg::*;
(
    input  logic [7:0]  op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] ld_word_i,
    output logic [31:0] st_data_o,
    output logic [3:0]  be_n_o,
    output logic [31:0] ld_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte   = ld_word_i[7:0];
        ld_half   = addr_lo_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
        st_data_o = st_data_i;
        be_n_o    = 4'b1111;
        ld_data_o = ld_word_i;

        case (addr_lo_i)
            2'd0:    ld_byte = ld_word_i[7:0];
            2'd1:    ld_byte = ld_word_i[15:8];
            2'd2:    ld_byte = ld_word_i[23:16];
            default: ld_byte = ld_word_i[31:24];
        endcase

        case (op_i)
            MEM_LB, MEM_LBU, MEM_SB: be_n_o = ~(4'b0001 << addr_lo_i);
            MEM_LH, MEM_LHU, MEM_SH: be_n_o = addr_lo_i[1] ? 4'b0011 : 4'b1100;
            MEM_LW, MEM_SW:          be_n_o = 4'b0000;
            default:                 be_n_o = 4'b1111;
        endcase

        // Replicated store data lets the SRAM pick the lane purely from be_n.
        case (op_i)
            MEM_SB:  st_data_o = {4{st_data_i[7:0]}};
            MEM_SH:  st_data_o = {2{st_data_i[15:0]}};
            default: st_data_o = st_data_i;
        endcase

        case (op_i)
            MEM_LB:  ld_data_o = {{24{ld_byte[7]}}, ld_byte};
            MEM_LBU: ld_data_o = {24'h0, ld_byte};
            MEM_LH:  ld_data_o = {{16{ld_half[15]}}, ld_half};
            MEM_LHU: ld_data_o = {16'h0, ld_half};
            default: ld_data_o = ld_word_i;
        endcase
    end

endmodule

// File: rtl/mem_dmem_ctrl.sv
// rtl/mem_dmem_ctrl.sv - MEM-stage data SRAM access FSM with wait states and writeback mux
module mem_dmem_ctrl
    import mem_dmem_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int RAM_AW      = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        mem_op_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       mem_data_i,
    input  logic              we_i,
    input  logic [4:0]        waddr_i,
    input  logic [31:0]       wdata_i,
    output logic              wb_we_o,
    output logic [4:0]        wb_waddr_o,
    output logic [31:0]       wb_wdata_o,
    output logic              stall_req_o,
    output logic              excp_adel_o,
    output logic              excp_ades_o,
    output logic              ram_ce_n_o,
    output logic              ram_oe_n_o,
    output logic              ram_we_n_o,
    output logic [3:0]        ram_be_n_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i
);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic [3:0]        be_n_q, be_n_d;
    logic [RAM_AW-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
    logic [7:0]        op_q, op_d;
    logic [1:0]        alo_q, alo_d;

    logic        ld_live, st_live, misal, acc_req;
    logic [7:0]  lane_op;
    logic [1:0]  lane_alo;
    logic [31:0] lane_st, lane_ld;
    logic [3:0]  lane_be_n;
    logic        unused_addr_hi;

    assign ld_live        = is_load(mem_op_i);
    assign st_live        = is_store(mem_op_i);
    assign misal          = is_misaligned(mem_op_i, mem_addr_i[1:0]);
    assign acc_req        = (ld_live | st_live) & ~misal;
    assign unused_addr_hi = ^mem_addr_i[31:RAM_AW+2];

    // IDLE steers the live op for store/be_n setup; later states extract with the latched op.
    assign lane_op  = (state_q == ST_IDLE) ? mem_op_i : op_q;
    assign lane_alo = (state_q == ST_IDLE) ? mem_addr_i[1:0] : alo_q;

    mem_lane_align u_lane (
        .op_i      (lane_op),
        .addr_lo_i (lane_alo),
        .st_data_i (mem_data_i),
        .ld_word_i (rdata_q),
        .st_data_o (lane_st),
        .be_n_o    (lane_be_n),
        .ld_data_o (lane_ld)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ce_n_d  = ce_n_q;
        oe_n_d  = oe_n_q;
        we_n_d  = we_n_q;
        be_n_d  = be_n_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        op_d    = op_q;
        alo_d   = alo_q;
        case (state_q)
            ST_IDLE: begin
                if (acc_req) begin
                    state_d = ST_ACCESS;
                    cnt_d   = 4'(WAIT_CYCLES);
                    ce_n_d  = 1'b0;
                    oe_n_d  = ~ld_live;
                    we_n_d  = ~st_live;
                    be_n_d  = lane_be_n;
                    addr_d  = mem_addr_i[RAM_AW+1:2];
                    wdata_d = lane_st;
                    op_d    = mem_op_i;
                    alo_d   = mem_addr_i[1:0];
                end
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    if (is_load(op_q)) rdata_d = ram_rdata_i;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            be_n_q  <= 4'hF;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            op_q    <= MEM_NOP;
            alo_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            be_n_q  <= be_n_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            op_q    <= op_d;
            alo_q   <= alo_d;
        end
    end

    always_comb begin
        stall_req_o = ((state_q == ST_IDLE) & acc_req) | (state_q == ST_ACCESS);
        excp_adel_o = (state_q == ST_IDLE) & ld_live & misal;
        excp_ades_o = (state_q == ST_IDLE) & st_live & misal;
        wb_we_o     = we_i;
        wb_waddr_o  = waddr_i;
        wb_wdata_o  = wdata_i;
        if (ld_live || st_live) wb_we_o = 1'b0;
        if (state_q == ST_DONE && is_load(op_q)) begin
            wb_we_o    = we_i;
            wb_wdata_o = lane_ld;
        end
        if (rst) begin
            stall_req_o = 1'b0;
            excp_adel_o = 1'b0;
            excp_ades_o = 1'b0;
            wb_we_o     = 1'b0;
            wb_waddr_o  = 5'd0;
            wb_wdata_o  = 32'h0;
        end
    end

    assign ram_ce_n_o  = ce_n_q;
    assign ram_oe_n_o  = oe_n_q;
    assign ram_we_n_o  = we_n_q;
    assign ram_be_n_o  = be_n_q;
    assign ram_addr_o  = addr_q;
    assign ram_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_dmem_ctrl.sv
// tb/tb_mem_dmem_ctrl.sv - directed table, random ops vs reference memory, reset and wait-state corners
module tb_mem_dmem_ctrl;

    localparam int W = 1;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic [7:0]  mem_op;
    logic [31:0] mem_addr, mem_data, wdata_in, wb_wdata, ram_wdata, ram_rdata;
    logic        we_in, wb_we, stall, adel, ades, ce_n, oe_n, we_n;
    logic [4:0]  waddr_in, wb_waddr;
    logic [3:0]  be_n;
    logic [19:0] ram_addr;

    logic [7:0]  op0;
    logic [31:0] addr0, data0, wdata_in0, wb_wdata0, ram_wdata0, ram_rdata0;
    logic        we_in0, wb_we0, stall0, adel0, ades0, ce_n0, oe_n0, we_n0;
    logic [4:0]  waddr_in0, wb_waddr0;
    logic [3:0]  be_n0;
    logic [19:0] ram_addr0;

    mem_dmem_ctrl #(.WAIT_CYCLES(W), .RAM_AW(20)) dut (
        .clk(clk), .rst(rst), .mem_op_i(mem_op), .mem_addr_i(mem_addr), .mem_data_i(mem_data),
        .we_i(we_in), .waddr_i(waddr_in), .wdata_i(wdata_in), .wb_we_o(wb_we), .wb_waddr_o(wb_waddr),
        .wb_wdata_o(wb_wdata), .stall_req_o(stall), .excp_adel_o(adel), .excp_ades_o(ades),
        .ram_ce_n_o(ce_n), .ram_oe_n_o(oe_n), .ram_we_n_o(we_n), .ram_be_n_o(be_n),
        .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
    );

    mem_dmem_ctrl #(.WAIT_CYCLES(0), .RAM_AW(20)) dut0 (
        .clk(clk), .rst(rst), .mem_op_i(op0), .mem_addr_i(addr0), .mem_data_i(data0),
        .we_i(we_in0), .waddr_i(waddr_in0), .wdata_i(wdata_in0), .wb_we_o(wb_we0), .wb_waddr_o(wb_waddr0),
        .wb_wdata_o(wb_wdata0), .stall_req_o(stall0), .excp_adel_o(adel0), .excp_ades_o(ades0),
        .ram_ce_n_o(ce_n0), .ram_oe_n_o(oe_n0), .ram_we_n_o(we_n0), .ram_be_n_o(be_n0),
        .ram_addr_o(ram_addr0), .ram_wdata_o(ram_wdata0), .ram_rdata_i(ram_rdata0)
    );

    // SRAM model: 256 words, byte-lane writes on every strobed edge, preload port for the bench.
    logic [31:0] sram [256];
    logic [31:0] ref_mem [256];
    logic        pre_en = 1'b0;
    logic [7:0]  pre_idx;
    logic [31:0] pre_val;

    assign ram_rdata  = !oe_n ? sram[ram_addr[7:0]] : 32'hA5A5_A5A5;
    assign ram_rdata0 = !oe_n0 ? 32'h0BAD_F00D : 32'h0;

    always @(posedge clk) begin
        if (pre_en) sram[pre_idx] <= pre_val;
        else if (!ce_n && !we_n)
            for (int k = 0; k < 4; k++)
                if (!be_n[k]) sram[ram_addr[7:0]][8*k +: 8] <= ram_wdata[8*k +: 8];
    end

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } in_t;

    typedef struct {
        int          stall;
        int          ce;
        int          wen;
        logic        adel;
        logic        ades;
        logic [3:0]  be_n;
        logic [19:0] raddr;
        logic [31:0] rwdata;
        logic        wb_we;
        logic [4:0]  wb_waddr;
        logic [31:0] wb_wdata;
    } out_t;

    typedef struct {
        in_t         i;
        logic [31:0] pre;
        out_t        e;
    } vec_t;

    task automatic preload(input logic [7:0] idx, input logic [31:0] val);
        @(posedge clk); #1;
        mem_op  = 8'h00;
        pre_idx = idx;
        pre_val = val;
        pre_en  = 1'b1;
        ref_mem[idx] = val;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    task automatic issue(input in_t v, output out_t o);
        int n;
        o = '{default: 0};
        @(posedge clk); #1;
        mem_op = v.op; mem_addr = v.addr; mem_data = v.data;
        we_in = v.we; waddr_in = v.waddr; wdata_in = v.wdata;
        #1;
        o.adel = adel;
        o.ades = ades;
        if (!ce_n) o.ce++;
        n = 0;
        while (stall && n < 40) begin
            n++;
            @(posedge clk); #3;
            if (!ce_n) begin
                o.ce++;
                o.be_n   = be_n;
                o.raddr  = ram_addr;
                o.rwdata = ram_wdata;
            end
            if (!we_n) o.wen++;
        end
        o.stall    = n;
        o.wb_we    = wb_we;
        o.wb_waddr = wb_waddr;
        o.wb_wdata = wb_wdata;
    endtask

    task automatic compare(input string tag, input out_t o, input out_t e);
        chk({tag, " stall_cycles"}, 32'(o.stall), 32'(e.stall));
        chk({tag, " ce_cycles"}, 32'(o.ce), 32'(e.ce));
        chk({tag, " we_cycles"}, 32'(o.wen), 32'(e.wen));
        chk({tag, " adel"}, 32'(o.adel), 32'(e.adel));
        chk({tag, " ades"}, 32'(o.ades), 32'(e.ades));
        chk({tag, " wb_we"}, 32'(o.wb_we), 32'(e.wb_we));
        if (e.stall > 0) begin
            chk({tag, " be_n"}, 32'(o.be_n), 32'(e.be_n));
            chk({tag, " ram_addr"}, 32'(o.raddr), 32'(e.raddr));
        end
        if (e.wen > 0) chk({tag, " ram_wdata"}, o.rwdata, e.rwdata);
        if (e.wb_we) begin
            chk({tag, " wb_waddr"}, 32'(o.wb_waddr), 32'(e.wb_waddr));
            chk({tag, " wb_wdata"}, o.wb_wdata, e.wb_wdata);
        end
    endtask

    // Reference: access size from op, alignment as addr mod size, memory as a plain word array.
    task automatic model(input in_t v, output out_t e);
        int          sz, idx;
        logic        ld, st, sgn;
        logic [1:0]  off;
        logic [31:0] val, mask;
        sz = 0; ld = 0; st = 0; sgn = 0;
        case (v.op)
            8'h20: begin sz = 1; ld = 1; sgn = 1; end
            8'h21: begin sz = 2; ld = 1; sgn = 1; end
            8'h23: begin sz = 4; ld = 1; end
            8'h24: begin sz = 1; ld = 1; end
            8'h25: begin sz = 2; ld = 1; end
            8'h28: begin sz = 1; st = 1; end
            8'h29: begin sz = 2; st = 1; end
            8'h2B: begin sz = 4; st = 1; end
            default: ;
        endcase
        e = '{default: 0};
        e.wb_waddr = v.waddr;
        off = v.addr[1:0];
        idx = int'(v.addr[9:2]);
        if (!ld && !st) begin
            e.wb_we    = v.we;
            e.wb_wdata = v.wdata;
        end else if ((v.addr % sz) != 0) begin
            e.adel = ld;
            e.ades = st;
        end else begin
            e.stall = W + 2;
            e.ce    = W + 1;
            e.wen   = st ? W + 1 : 0;
            e.raddr = v.addr[21:2];
            mask    = ((32'h1 << sz) - 1) << off;
            e.be_n  = ~mask[3:0];
            if (st) begin
                val = (sz == 4) ? v.data : v.data & ((32'h1 << (8 * sz)) - 1);
                e.rwdata = (sz == 1) ? val * 32'h0101_0101 : (sz == 2) ? val * 32'h0001_0001 : val;
                for (int k = 0; k < 4; k++)
                    if (mask[k]) ref_mem[idx][8*k +: 8] = e.rwdata[8*k +: 8];
            end else begin
                val = ref_mem[idx] >> (8 * off);
                if (sz < 4) begin
                    val = val & ((32'h1 << (8 * sz)) - 1);
                    if (sgn && val[8*sz-1]) val = val - (32'h1 << (8 * sz));
                end
                e.wb_we    = v.we;
                e.wb_wdata = val;
            end
        end
    endtask

    function automatic vec_t mk(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                                input logic we, input logic [31:0] pre, input int stl, input int wen,
                                input logic adl, input logic ads, input logic [3:0] bn, input logic [19:0] ra,
                                input logic [31:0] rwd, input logic wbwe, input logic [31:0] wbd);
        vec_t t;
        t.i = '{op: op, addr: addr, data: data, we: we, waddr: 5'd3, wdata: 32'h1111_1111};
        t.pre = pre;
        t.e = '{stall: stl, ce: (stl > 0) ? W + 1 : 0, wen: wen, adel: adl, ades: ads, be_n: bn,
                raddr: ra, rwdata: rwd, wb_we: wbwe, wb_waddr: 5'd3, wb_wdata: wbd};
        return t;
    endfunction

    vec_t        tbl[$];
    in_t         v;
    out_t        o, e;
    logic [7:0]  ops [12];
    int          n;

    initial begin
        rst = 1'b1;
        mem_op = 8'h00; mem_addr = 32'h0; mem_data = 32'h0;
        we_in = 1'b1; waddr_in = 5'd9; wdata_in = 32'h1234_5678;
        op0 = 8'h00; addr0 = 32'h0; data0 = 32'h0; we_in0 = 1'b1; waddr_in0 = 5'd1; wdata_in0 = 32'h0;
        pre_idx = 8'h0; pre_val = 32'h0;

        for (int i = 0; i < 256; i++) preload(8'(i), $urandom);
        #2;
        chk("rst wb_we", 32'(wb_we), 32'h0);
        chk("rst wb_wdata", wb_wdata, 32'h0);
        chk("rst strobes ce/oe/we", {29'h0, ce_n, oe_n, we_n}, 32'h7);
        chk("rst be_n", 32'(be_n), 32'hF);
        chk("rst ram_addr", 32'(ram_addr), 32'h0);
        chk("rst ram_wdata", ram_wdata, 32'h0);
        mem_op = 8'h23; mem_addr = 32'h100; #1;
        chk("rst stall", 32'(stall), 32'h0);
        mem_addr = 32'h102; #1;
        chk("rst adel", 32'(adel), 32'h0);
        @(posedge clk); #1;
        mem_op = 8'h00;
        rst = 1'b0;

        tbl.push_back(mk(8'h23, 32'h100, 32'h0,        1'b1, 32'hDEAD_BEEF, 3, 0, 0, 0, 4'b0000, 20'h40, 32'h0,         1'b1, 32'hDEAD_BEEF));
        tbl.push_back(mk(8'h20, 32'h103, 32'h0,        1'b1, 32'h80FF_1234, 3, 0, 0, 0, 4'b0111, 20'h40, 32'h0,         1'b1, 32'hFFFF_FF80));
        tbl.push_back(mk(8'h24, 32'h103, 32'h0,        1'b1, 32'h80FF_1234, 3, 0, 0, 0, 4'b0111, 20'h40, 32'h0,         1'b1, 32'h0000_0080));
        tbl.push_back(mk(8'h21, 32'h102, 32'h0,        1'b1, 32'h80FF_1234, 3, 0, 0, 0, 4'b0011, 20'h40, 32'h0,         1'b1, 32'hFFFF_80FF));
        tbl.push_back(mk(8'h25, 32'h102, 32'h0,        1'b1, 32'h80FF_1234, 3, 0, 0, 0, 4'b0011, 20'h40, 32'h0,         1'b1, 32'h0000_80FF));
        tbl.push_back(mk(8'h29, 32'h202, 32'h0000_ABCD, 1'b0, 32'h0,        3, 2, 0, 0, 4'b0011, 20'h80, 32'hABCD_ABCD, 1'b0, 32'h0));
        tbl.push_back(mk(8'h28, 32'h205, 32'h1234_56A5, 1'b1, 32'h0,        3, 2, 0, 0, 4'b1101, 20'h81, 32'hA5A5_A5A5, 1'b0, 32'h0));
        tbl.push_back(mk(8'h23, 32'h102, 32'h0,        1'b1, 32'h0,        0, 0, 1, 0, 4'b1111, 20'h0,  32'h0,         1'b0, 32'h0));
        tbl.push_back(mk(8'h2B, 32'h101, 32'h0,        1'b1, 32'h0,        0, 0, 0, 1, 4'b1111, 20'h0,  32'h0,         1'b0, 32'h0));
        tbl.push_back(mk(8'h25, 32'h101, 32'h0,        1'b1, 32'h0,        0, 0, 1, 0, 4'b1111, 20'h0,  32'h0,         1'b0, 32'h0));
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].i.op inside {8'h20, 8'h21, 8'h23, 8'h24, 8'h25})
                preload(tbl[i].i.addr[9:2], tbl[i].pre);
            issue(tbl[i].i, o);
            compare($sformatf("vec%0d", i), o, tbl[i].e);
        end
        chk("sh sram word upper", 32'(sram[8'h80][31:16]), 32'hABCD);
        chk("sb sram byte1", 32'(sram[8'h81][15:8]), 32'hA5);

        v = '{op: 8'h00, addr: 32'h0, data: 32'h0, we: 1'b1, waddr: 5'd5, wdata: 32'd7};
        issue(v, o);
        e = '{default: 0};
        e.wb_we = 1'b1; e.wb_waddr = 5'd5; e.wb_wdata = 32'd7;
        compare("nop passthrough", o, e);

        ops = '{8'h00, 8'h20, 8'h21, 8'h23, 8'h24, 8'h25, 8'h28, 8'h29, 8'h2B, 8'h22, 8'h2A, 8'hFF};
        for (int i = 0; i < 250; i++) begin
            v.op    = ops[$urandom_range(0, 11)];
            v.addr  = 32'($urandom_range(0, 255));
            v.data  = $urandom;
            v.we    = 1'($urandom_range(0, 1));
            v.waddr = 5'($urandom_range(0, 31));
            v.wdata = $urandom;
            model(v, e);
            issue(v, o);
            compare($sformatf("rnd%0d op%02h a%02h", i, v.op, v.addr[7:0]), o, e);
        end

        @(posedge clk); #1;
        mem_op = 8'h00;
        op0 = 8'h23; addr0 = 32'h10;
        #1;
        n = 0;
        while (stall0 && n < 20) begin
            n++;
            @(posedge clk); #3;
        end
        chk("w0 stall_cycles", 32'(n), 32'd2);
        chk("w0 wb_we", 32'(wb_we0), 32'h1);
        chk("w0 wb_wdata", wb_wdata0, 32'h0BAD_F00D);
        @(posedge clk); #1;
        op0 = 8'h00;

        @(posedge clk); #1;
        mem_op = 8'h2B; mem_addr = 32'h300; mem_data = 32'h1234_5678; we_in = 1'b0;
        @(posedge clk); #1;
        chk("rst-mid access1 we_n", 32'(we_n), 32'h0);
        @(posedge clk); #1;
        chk("rst-mid access2 we_n", 32'(we_n), 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst-mid we_n", 32'(we_n), 32'h1);
        chk("rst-mid ce_n", 32'(ce_n), 32'h1);
        chk("rst-mid stall", 32'(stall), 32'h0);
        mem_op = 8'h00;
        rst = 1'b0;
        #1;
        chk("rst-mid idle stall", 32'(stall), 32'h0);
        @(posedge clk); #1;
        chk("rst-mid idle ce_n", 32'(ce_n), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
